// File: rtl/rock_scheduler_pkg.sv
// Shared state encoding and default tuning constants for the rock scheduler.
// Pure declarations; no logic, no latency, no flow control.
package rock_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD      = 3'd2,
        RAMP_DOWN = 3'd3,
        DRAIN     = 3'd4,
        STOP      = 3'd5
    } state_e;

    localparam int unsigned QUIET_TICKS_DEF = 8;
    localparam int unsigned HOLD_TICKS_DEF  = 4;
    localparam int unsigned F_MAX_DEF       = 6;

endpackage

// File: rtl/rock_scheduler_sat_counter.sv
// 4-bit saturating event counter; tc_o flags that the next increment reaches LIMIT.
// Updates one clk after clr_i/inc_i; no backpressure, clear wins over increment.
module sat_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (32'(cnt_q) + 32'd1) >= LIMIT;

endmodule

// File: rtl/rock_scheduler.sv
// Cradle-rocking scheduler: steers a frequency/amplitude generator with one-clk raise/lower pulses.
// Pulses are registered (1 clk after an accepted tick); the tick right after any pulse is dropped.
module rock_scheduler
    import rock_scheduler_pkg::*;
#(
    parameter int unsigned QUIET_TICKS = QUIET_TICKS_DEF,
    parameter int unsigned HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int unsigned F_MAX       = F_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       cry,
    input  logic [2:0] F,
    input  logic [2:0] A,
    input  logic       F0,
    output logic       Fhoog,
    output logic       Flaag,
    output logic       Alaag,
    output logic [2:0] state,
    output logic       done
);

    state_e state_q, state_d;
    logic   fhoog_q, fhoog_d;
    logic   flaag_q, flaag_d;
    logic   alaag_q, alaag_d;
    logic   done_q;
    logic   ign_q, ign_d;
    logic   acc;
    logic   at_max;
    logic   can_up;
    logic   q_clr, q_inc, q_tc;
    logic   h_clr, h_inc, h_tc;

    sat_counter #(.LIMIT(QUIET_TICKS)) u_quiet (
        .clk   (clk),
        .reset (reset),
        .clr_i (q_clr),
        .inc_i (q_inc),
        .tc_o  (q_tc)
    );

    sat_counter #(.LIMIT(HOLD_TICKS)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr_i (h_clr),
        .inc_i (h_inc),
        .tc_o  (h_tc)
    );

    // The generator only settles on the negedge after a pulse, so that tick is dropped.
    assign acc    = tick & ~ign_q;
    assign at_max = 32'(F) >= F_MAX;
    assign can_up = ~at_max & ~F0;

    always_comb begin
        state_d = state_q;
        fhoog_d = 1'b0;
        flaag_d = 1'b0;
        alaag_d = 1'b0;
        q_clr   = 1'b0;
        q_inc   = 1'b0;
        h_clr   = 1'b0;
        h_inc   = 1'b0;
        if (acc) begin
            case (state_q)
                IDLE: begin
                    if (cry) begin
                        state_d = RAMP_UP;
                        fhoog_d = can_up;
                    end
                end
                RAMP_UP: begin
                    if (cry) begin
                        q_clr = 1'b1;
                        if (at_max) begin
                            state_d = HOLD;
                        end else begin
                            fhoog_d = can_up;
                        end
                    end else begin
                        q_inc = 1'b1;
                        if (q_tc) begin
                            state_d = RAMP_DOWN;
                        end
                    end
                end
                HOLD: begin
                    if (cry) begin
                        h_clr = 1'b1;
                    end else begin
                        h_inc   = 1'b1;
                        alaag_d = A > 3'd1;
                        if (h_tc) begin
                            state_d = RAMP_DOWN;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (cry) begin
                        state_d = RAMP_UP;
                    end else begin
                        flaag_d = ~F0;
                        if (F == 3'd1) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (F0 && (A == 3'd0)) begin
                        state_d = STOP;
                    end
                end
                default: ;
            endcase
        end
        // Every state change starts both counters from zero.
        if (state_d != state_q) begin
            q_clr = 1'b1;
            h_clr = 1'b1;
        end
    end

    assign ign_d = fhoog_d | flaag_d | alaag_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fhoog_q <= 1'b0;
            flaag_q <= 1'b0;
            alaag_q <= 1'b0;
            done_q  <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fhoog_q <= fhoog_d;
            flaag_q <= flaag_d;
            alaag_q <= alaag_d;
            done_q  <= (state_d == STOP);
            ign_q   <= ign_d;
        end
    end

    assign Fhoog = fhoog_q;
    assign Flaag = flaag_q;
    assign Alaag = alaag_q;
    assign state = state_q;
    assign done  = done_q;

endmodule
